// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 monitor: alarm FSM state encoding,
// default thresholds and timeout, rounded-sample width and the rounding helper.
package dht11_pkg;

   localparam int RND_W = 8;

   localparam logic [7:0]  DEF_TEMP_HI     = 8'd35;
   localparam logic [7:0]  DEF_HUMI_HI     = 8'd80;
   localparam logic [7:0]  DEF_HYST        = 8'd2;
   localparam int          DEF_CONFIRM_N   = 3;
   localparam logic [27:0] DEF_TIMEOUT_CNT = 28'd250_000_000;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_PEND_ON  = 2'd1,
      ST_ALARM    = 2'd2,
      ST_PEND_OFF = 2'd3
   } thresh_state_t;

   // Integer part rounded up when the tenths digit is 5 or more, saturating at 255.
   function automatic logic [RND_W-1:0] round_sample(input logic [7:0] int_part,
                                                     input logic [7:0] deci_part);
      logic [RND_W:0] sum;
      sum = {1'b0, int_part} + {{RND_W{1'b0}}, (deci_part >= 8'd5)};
      if (sum[RND_W])
         return {RND_W{1'b1}};
      else
         return sum[RND_W-1:0];
   endfunction

endpackage

// File: rtl/dht11_thresh_fsm.sv
// Per-channel over-threshold alarm with confirmation counting and hysteresis.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_OK       | no alarm, value below threshold
// ST_PEND_ON  | value at/above threshold, counting confirmations to raise
// ST_ALARM    | alarm confirmed
// ST_PEND_OFF | value at/below release level, counting confirmations to drop
module dht11_thresh_fsm
   import dht11_pkg::*;
#(
   parameter logic [7:0] HI        = DEF_TEMP_HI,
   parameter logic [7:0] HYST      = DEF_HYST,
   parameter int         CONFIRM_N = DEF_CONFIRM_N
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       sample_en,
   input  logic [7:0] value,
   output logic       alarm
);

   // Release level saturates at zero so a large hysteresis cannot wrap.
   localparam logic [7:0] LO        = (HI >= HYST) ? (HI - HYST) : 8'd0;
   localparam logic [4:0] CONFIRM_W = 5'(CONFIRM_N);

   thresh_state_t state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [4:0]    cnt_inc;
   logic          over, under;

   assign over    = (value >= HI);
   assign under   = (value <= LO);
   assign cnt_inc = {1'b0, cnt} + 5'd1;

   // State and confirm counter register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= ST_OK;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; only a qualified sample can move the FSM.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (sample_en) begin
         case (state)
            ST_OK: begin
               if (over) begin
                  if (CONFIRM_W == 5'd1) begin
                     state_nxt = ST_ALARM;
                     cnt_nxt   = 4'd0;
                  end else begin
                     state_nxt = ST_PEND_ON;
                     cnt_nxt   = 4'd1;
                  end
               end
            end
            ST_PEND_ON: begin
               if (over) begin
                  if (cnt_inc >= CONFIRM_W) begin
                     state_nxt = ST_ALARM;
                     cnt_nxt   = 4'd0;
                  end else begin
                     cnt_nxt   = cnt_inc[3:0];
                  end
               end else begin
                  state_nxt = ST_OK;
                  cnt_nxt   = 4'd0;
               end
            end
            ST_ALARM: begin
               if (under) begin
                  if (CONFIRM_W == 5'd1) begin
                     state_nxt = ST_OK;
                     cnt_nxt   = 4'd0;
                  end else begin
                     state_nxt = ST_PEND_OFF;
                     cnt_nxt   = 4'd1;
                  end
               end
            end
            ST_PEND_OFF: begin
               if (under) begin
                  if (cnt_inc >= CONFIRM_W) begin
                     state_nxt = ST_OK;
                     cnt_nxt   = 4'd0;
                  end else begin
                     cnt_nxt   = cnt_inc[3:0];
                  end
               end else begin
                  state_nxt = ST_ALARM;
                  cnt_nxt   = 4'd0;
               end
            end
            default: begin
               state_nxt = ST_OK;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // Alarm stays asserted while a release is still being confirmed.
   assign alarm = (state == ST_ALARM) || (state == ST_PEND_OFF);

endmodule

// File: rtl/dht11_monitor.sv
// DHT11 sample monitor: rounds each checksum-good sample, raises confirmed
// temperature/humidity alarms, watches for a silent sensor and optionally
// tracks temperature extremes.
// Build option: define DHT11_MINMAX_EN to include min/max temperature
// tracking; without it temp_max/temp_min read 0 and clr_minmax is ignored.
module dht11_monitor
   import dht11_pkg::*;
#(
   parameter logic [7:0]  TEMP_HI     = DEF_TEMP_HI,
   parameter logic [7:0]  HUMI_HI     = DEF_HUMI_HI,
   parameter logic [7:0]  HYST        = DEF_HYST,
   parameter int          CONFIRM_N   = DEF_CONFIRM_N,
   parameter logic [27:0] TIMEOUT_CNT = DEF_TIMEOUT_CNT
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] humi_int,
   input  logic [7:0] humi_deci,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_deci,
   input  logic       dht11_valid,
   input  logic       clr_minmax,
   output logic [7:0] temp_cur,
   output logic [7:0] humi_cur,
   output logic       new_sample,
   output logic       temp_alarm,
   output logic       humi_alarm,
   output logic       sensor_fault,
   output logic [7:0] temp_max,
   output logic [7:0] temp_min
);

   logic [RND_W-1:0] temp_rnd, humi_rnd;
   logic [27:0]      wd_cnt;
   logic             fsm_en;

   // Rounded values are only consumed in dht11_valid cycles.
   assign temp_rnd = round_sample(temp_int, temp_deci);
   assign humi_rnd = round_sample(humi_int, humi_deci);

   // A sample arriving while faulted only clears the fault; the FSMs stay frozen.
   assign fsm_en = dht11_valid && !sensor_fault;

   // Latest-sample registers and the one-cycle new_sample strobe.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         temp_cur   <= 8'd0;
         humi_cur   <= 8'd0;
         new_sample <= 1'b0;
      end else begin
         new_sample <= dht11_valid;
         if (dht11_valid) begin
            temp_cur <= temp_rnd;
            humi_cur <= humi_rnd;
         end
      end
   end

   // Watchdog: counts idle cycles and latches sensor_fault on reaching the limit;
   // a sample in the limit cycle itself takes priority.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         wd_cnt       <= 28'd0;
         sensor_fault <= 1'b0;
      end else if (dht11_valid) begin
         wd_cnt       <= 28'd0;
         sensor_fault <= 1'b0;
      end else begin
         if (wd_cnt != TIMEOUT_CNT)
            wd_cnt <= wd_cnt + 28'd1;
         if (wd_cnt == TIMEOUT_CNT - 28'd1)
            sensor_fault <= 1'b1;
      end
   end

   dht11_thresh_fsm #(
      .HI        (TEMP_HI),
      .HYST      (HYST),
      .CONFIRM_N (CONFIRM_N)
   ) u_temp_fsm (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sample_en (fsm_en),
      .value     (temp_rnd),
      .alarm     (temp_alarm)
   );

   dht11_thresh_fsm #(
      .HI        (HUMI_HI),
      .HYST      (HYST),
      .CONFIRM_N (CONFIRM_N)
   ) u_humi_fsm (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sample_en (fsm_en),
      .value     (humi_rnd),
      .alarm     (humi_alarm)
   );

`ifdef DHT11_MINMAX_EN
   // Temperature extremes; a clear coinciding with a sample seeds both with it.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         temp_max <= 8'd0;
         temp_min <= 8'd255;
      end else if (clr_minmax) begin
         if (dht11_valid) begin
            temp_max <= temp_rnd;
            temp_min <= temp_rnd;
         end else begin
            temp_max <= 8'd0;
            temp_min <= 8'd255;
         end
      end else if (dht11_valid) begin
         if (temp_rnd > temp_max)
            temp_max <= temp_rnd;
         if (temp_rnd < temp_min)
            temp_min <= temp_rnd;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = clr_minmax;
   assign temp_max   = 8'd0;
   assign temp_min   = 8'd0;
`endif

endmodule

// File: tb/tb_dht11_monitor.sv
// Directed bench for dht11_monitor with a short watchdog limit.
module tb_dht11_monitor;
   localparam logic [27:0] TMO = 28'd200;
`ifdef DHT11_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] humi_int, humi_deci, temp_int, temp_deci;
   logic       dht11_valid, clr_minmax;
   logic [7:0] temp_cur, humi_cur, temp_max, temp_min;
   logic       new_sample, temp_alarm, humi_alarm, sensor_fault;

   int n_vec = 0;
   int n_err = 0;

   dht11_monitor #(.TIMEOUT_CNT(TMO)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .humi_int     (humi_int),
      .humi_deci    (humi_deci),
      .temp_int     (temp_int),
      .temp_deci    (temp_deci),
      .dht11_valid  (dht11_valid),
      .clr_minmax   (clr_minmax),
      .temp_cur     (temp_cur),
      .humi_cur     (humi_cur),
      .new_sample   (new_sample),
      .temp_alarm   (temp_alarm),
      .humi_alarm   (humi_alarm),
      .sensor_fault (sensor_fault),
      .temp_max     (temp_max),
      .temp_min     (temp_min)
   );

   always #10 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one valid sample; returns at the negedge after it was captured.
   task automatic samp(input logic [7:0] ti, input logic [7:0] td,
                       input logic [7:0] hi, input logic [7:0] hd, input logic clr);
      @(negedge sys_clk);
      temp_int = ti; temp_deci = td; humi_int = hi; humi_deci = hd;
      dht11_valid = 1'b1; clr_minmax = clr;
      @(negedge sys_clk);
      dht11_valid = 1'b0; clr_minmax = 1'b0;
      check_eq("new_sample", new_sample, 1);
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      humi_int = 0; humi_deci = 0; temp_int = 0; temp_deci = 0;
      dht11_valid = 0; clr_minmax = 0;
      repeat (3) @(negedge sys_clk);
      check_eq("rst temp_cur", temp_cur, 0);
      check_eq("rst humi_cur", humi_cur, 0);
      check_eq("rst new_sample", new_sample, 0);
      check_eq("rst temp_alarm", temp_alarm, 0);
      check_eq("rst humi_alarm", humi_alarm, 0);
      check_eq("rst fault", sensor_fault, 0);
      check_eq("rst temp_max", temp_max, 0);
      check_eq("rst temp_min", temp_min, MM ? 255 : 0);
      sys_rst_n = 1'b1;

      // Alarm raise after three confirmations
      samp(36, 0, 50, 0, 0);
      check_eq("cur t36", temp_cur, 36);
      check_eq("cur h50", humi_cur, 50);
      check_eq("ta 36#1", temp_alarm, 0);
      samp(36, 0, 50, 0, 0);
      check_eq("ta 36#2", temp_alarm, 0);
      samp(36, 0, 50, 0, 0);
      check_eq("ta 36#3", temp_alarm, 1);
      @(negedge sys_clk);
      check_eq("new_sample pulse", new_sample, 0);

      // Release with hysteresis
      samp(34, 0, 50, 0, 0); check_eq("ta 34", temp_alarm, 1);
      samp(33, 0, 50, 0, 0); check_eq("ta 33#1", temp_alarm, 1);
      samp(33, 0, 50, 0, 0); check_eq("ta 33#2", temp_alarm, 1);
      samp(33, 0, 50, 0, 0); check_eq("ta 33#3", temp_alarm, 0);

      // Rounding and saturation
      samp(34, 5, 50, 0, 0); check_eq("round 34.5", temp_cur, 35);
      samp(255, 9, 50, 0, 0); check_eq("round 255.9", temp_cur, 255);
      check_eq("ta pend", temp_alarm, 0);
      samp(20, 0, 50, 0, 0); check_eq("ta back ok", temp_alarm, 0);

      // Humidity channel: raise, aborted release, full release
      samp(20, 0, 85, 0, 0); check_eq("ha 85", humi_alarm, 0);
      samp(20, 0, 79, 5, 0); check_eq("round h79.5", humi_cur, 80);
      check_eq("ha 80", humi_alarm, 0);
      samp(20, 0, 90, 0, 0); check_eq("ha 90", humi_alarm, 1);
      samp(20, 0, 78, 4, 0); check_eq("cur h78", humi_cur, 78);
      check_eq("ha 78", humi_alarm, 1);
      samp(20, 0, 79, 0, 0); check_eq("ha 79", humi_alarm, 1);
      samp(20, 0, 50, 0, 0); check_eq("ha 50#1", humi_alarm, 1);
      samp(20, 0, 50, 0, 0); check_eq("ha 50#2", humi_alarm, 1);
      samp(20, 0, 50, 0, 0); check_eq("ha 50#3", humi_alarm, 0);

      // Reset mid-confirmation discards partial count
      do_reset();
      samp(36, 0, 50, 0, 0); check_eq("pre-rst 36#1", temp_alarm, 0);
      samp(36, 0, 50, 0, 0); check_eq("pre-rst 36#2", temp_alarm, 0);
      do_reset();
      samp(36, 0, 50, 0, 0); check_eq("post-rst 36#1", temp_alarm, 0);
      samp(36, 0, 50, 0, 0); check_eq("post-rst 36#2", temp_alarm, 0);
      samp(36, 0, 50, 0, 0); check_eq("post-rst 36#3", temp_alarm, 1);

      // Min/max tracking
      do_reset();
      samp(20, 0, 50, 0, 0);
      check_eq("max 20", temp_max, MM ? 20 : 0);
      check_eq("min 20", temp_min, MM ? 20 : 0);
      samp(30, 0, 50, 0, 0);
      samp(25, 0, 50, 0, 0);
      check_eq("max 30", temp_max, MM ? 30 : 0);
      check_eq("min 20b", temp_min, MM ? 20 : 0);
      samp(22, 0, 50, 0, 1);
      check_eq("clr+valid max", temp_max, MM ? 22 : 0);
      check_eq("clr+valid min", temp_min, MM ? 22 : 0);
      @(negedge sys_clk);
      clr_minmax = 1'b1;
      @(negedge sys_clk);
      clr_minmax = 1'b0;
      check_eq("clr max", temp_max, 0);
      check_eq("clr min", temp_min, MM ? 255 : 0);

      // Watchdog timeout, hold and recovery
      samp(20, 0, 50, 0, 0);
      repeat (int'(TMO) - 1) @(negedge sys_clk);
      check_eq("fault before tmo", sensor_fault, 0);
      @(negedge sys_clk);
      check_eq("fault at tmo", sensor_fault, 1);
      repeat (5) @(negedge sys_clk);
      check_eq("fault held", sensor_fault, 1);
      samp(20, 0, 50, 0, 0);
      check_eq("fault cleared", sensor_fault, 0);

      // Sample landing exactly in the timeout cycle wins
      repeat (int'(TMO) - 2) @(negedge sys_clk);
      samp(20, 0, 50, 0, 0);
      check_eq("fault valid@tmo", sensor_fault, 0);
      @(negedge sys_clk);
      check_eq("fault valid@tmo+1", sensor_fault, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
